// File: rtl/gmii_to_fifo24_pkg.sv
// gmii_to_fifo24_pkg
// Shared definitions for the GMII UDP stream receiver: parser states, framing
// constants, header byte offsets (counted from the first byte after the SFD)
// and the accepted UDP destination port helper.
package gmii_to_fifo24_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        HEADER,
        VIDEO,
        AUDIO,
        DROP
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [15:0] UDP_PORT_BASE  = 16'h3000;
    localparam logic [7:0]  TYPE_VIDEO     = 8'h00;
    localparam logic [7:0]  TYPE_AUDIO     = 8'h01;

    // Ethernet(14) + IPv4(20) + UDP(8); also the offset of the payload type byte.
    localparam logic [10:0] HDR_LEN        = 11'd42;
    localparam logic [15:0] UDP_HDR_LEN    = 16'd8;
    localparam logic [10:0] CNT_MAX        = 11'd2047;

    localparam logic [10:0] OFS_ETYPE_HI   = 11'd12;
    localparam logic [10:0] OFS_ETYPE_LO   = 11'd13;
    localparam logic [10:0] OFS_IP_PROTO   = 11'd23;
    localparam logic [10:0] OFS_UDP_DST_HI = 11'd36;
    localparam logic [10:0] OFS_UDP_DST_LO = 11'd37;
    localparam logic [10:0] OFS_UDP_LEN_HI = 11'd38;
    localparam logic [10:0] OFS_UDP_LEN_LO = 11'd39;

    function automatic logic [15:0] udp_port_for(input logic sel);
        return UDP_PORT_BASE + {15'b0, sel};
    endfunction

endpackage

// File: rtl/byte3_packer.sv
// byte3_packer
// Collects a byte stream into 3-byte groups, MSB first.
//   clk125      rising-edge clock
//   sys_rst_n   synchronous active-low reset
//   clear       restarts the group phase (held while not inside a payload)
//   byte_valid  byte_in carries the next stream byte this cycle
//   byte_in     stream byte
//   group_done  combinational: byte_in completes a group this cycle
//   group_word  combinational: {first, second, byte_in}, valid with group_done
module byte3_packer (
    input  logic        clk125,
    input  logic        sys_rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        group_done,
    output logic [23:0] group_word
);

    logic [1:0]  phase;
    logic [15:0] sr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk125) begin
        if (!sys_rst_n) begin
            phase <= 2'd0;
            sr    <= 16'd0;
        end else if (clear) begin
            phase <= 2'd0;
        end else if (byte_valid) begin
            sr    <= {sr[7:0], byte_in};
            phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        end
    end

    // The third byte is not stored: the group is emitted straight from the
    // shift register plus the live byte, so the caller registers it once.
    assign group_done = byte_valid && !clear && (phase == 2'd2);
    assign group_word = {sr, byte_in};

endmodule

// File: rtl/gmii_to_fifo24.sv
// gmii_to_fifo24
// Parses GMII receive frames carrying UDP video/audio payloads and emits
// 3-byte words with one-cycle write strobes.
//   clk125       125 MHz GMII receive clock
//   sys_rst_n    synchronous active-low reset
//   id           stream select; accepted UDP dst port = 0x3000 + id
//   rxd, rx_dv   GMII receive data / data valid
//   datain       video word {line[4:0], R, G, B}, written with recv_en
//   recv_en      one-cycle video write strobe
//   packet_en    high while an accepted frame's payload is being parsed
//   aux_data_in  audio word {b0, b1, b2}, written with aux_wr_en
//   aux_wr_en    one-cycle audio write strobe
module gmii_to_fifo24
    import gmii_to_fifo24_pkg::*;
(
    input  logic        clk125,
    input  logic        sys_rst_n,
    input  logic        id,
    input  logic [7:0]  rxd,
    input  logic        rx_dv,
    output logic [28:0] datain,
    output logic        recv_en,
    output logic        packet_en,
    output logic [23:0] aux_data_in,
    output logic        aux_wr_en
);

    // Header position of the first byte past the UDP payload is udp_len + 34.
    localparam logic [16:0] LEN_TO_END = 17'(HDR_LEN) - 17'(UDP_HDR_LEN);

    state_t      state, state_nxt;
    logic [10:0] byte_cnt;
    logic [15:0] udp_len;
    logic [4:0]  line_lo;     // only line[4:0] ever reaches datain
    logic [15:0] dst_port;
    logic [16:0] payload_end;
    logic [10:0] pay_idx;
    logic        in_payload_st;
    logic        in_payload;
    logic        counting;
    logic        pack_valid;
    logic        group_done;
    logic [23:0] group_word;
    logic        video_group;
    logic        audio_group;

    assign dst_port      = udp_port_for(id);
    assign in_payload_st = (state == VIDEO) || (state == AUDIO);
    assign payload_end   = {1'b0, udp_len} + LEN_TO_END;
    // A saturated counter no longer identifies a byte, so it never counts as payload.
    assign in_payload    = ({6'b0, byte_cnt} < payload_end) && (byte_cnt != CNT_MAX);
    assign pay_idx       = byte_cnt - HDR_LEN;
    assign counting      = rx_dv && ((state == HEADER) || in_payload_st);
    assign pack_valid    = rx_dv && in_payload &&
                           (((state == VIDEO) && (pay_idx >= 11'd3)) ||
                            ((state == AUDIO) && (pay_idx >= 11'd1)));
    assign video_group   = group_done && (state == VIDEO);
    assign audio_group   = group_done && (state == AUDIO);
    assign packet_en     = in_payload_st;

    byte3_packer u_packer (
        .clk125     (clk125),
        .sys_rst_n  (sys_rst_n),
        .clear      (!in_payload_st),
        .byte_valid (pack_valid),
        .byte_in    (rxd),
        .group_done (group_done),
        .group_word (group_word)
    );

    // NOTE: next state gets its default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (!rx_dv) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rxd == PREAMBLE_BYTE) state_nxt = PREAMBLE;
                end
                PREAMBLE: begin
                    if (rxd == SFD_BYTE)           state_nxt = HEADER;
                    else if (rxd != PREAMBLE_BYTE) state_nxt = DROP;
                end
                HEADER: begin
                    case (byte_cnt)
                        OFS_ETYPE_HI:   if (rxd != ETHERTYPE_IPV4[15:8]) state_nxt = DROP;
                        OFS_ETYPE_LO:   if (rxd != ETHERTYPE_IPV4[7:0])  state_nxt = DROP;
                        OFS_IP_PROTO:   if (rxd != IP_PROTO_UDP)         state_nxt = DROP;
                        OFS_UDP_DST_HI: if (rxd != dst_port[15:8])       state_nxt = DROP;
                        OFS_UDP_DST_LO: if (rxd != dst_port[7:0])        state_nxt = DROP;
                        HDR_LEN: begin
                            // Type byte: also rejected when the UDP length leaves no payload.
                            if (!in_payload)             state_nxt = DROP;
                            else if (rxd == TYPE_VIDEO)  state_nxt = VIDEO;
                            else if (rxd == TYPE_AUDIO)  state_nxt = AUDIO;
                            else                         state_nxt = DROP;
                        end
                        default: ;
                    endcase
                end
                VIDEO, AUDIO, DROP: ;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk125) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            byte_cnt    <= 11'd0;
            udp_len     <= 16'd0;
            line_lo     <= 5'd0;
            recv_en     <= 1'b0;
            aux_wr_en   <= 1'b0;
            datain      <= 29'd0;
            aux_data_in <= 24'd0;
        end else begin
            state <= state_nxt;

            // Zero outside header/payload so the first byte after the SFD is byte 0.
            if (counting) byte_cnt <= (byte_cnt == CNT_MAX) ? CNT_MAX : byte_cnt + 11'd1;
            else          byte_cnt <= 11'd0;

            if ((state == HEADER) && rx_dv) begin
                if (byte_cnt == OFS_UDP_LEN_HI) udp_len[15:8] <= rxd;
                if (byte_cnt == OFS_UDP_LEN_LO) udp_len[7:0]  <= rxd;
            end

            if ((state == VIDEO) && rx_dv && in_payload && (pay_idx == 11'd2))
                line_lo <= rxd[4:0];

            recv_en   <= video_group;
            aux_wr_en <= audio_group;
            if (video_group) datain      <= {line_lo, group_word};
            if (audio_group) aux_data_in <= group_word;
        end
    end

endmodule

// File: tb/tb_gmii_to_fifo24.sv
// tb_gmii_to_fifo24
// Self-checking bench: builds byte-level frames, predicts the written words
// with a frame-level reference model and compares them with what the DUT
// strobes out.
module tb_gmii_to_fifo24;

    logic        clk125 = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        id = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic        rx_dv = 1'b0;
    logic [28:0] datain;
    logic        recv_en;
    logic        packet_en;
    logic [23:0] aux_data_in;
    logic        aux_wr_en;

    always #4 clk125 = ~clk125;

    gmii_to_fifo24 dut (
        .clk125      (clk125),
        .sys_rst_n   (sys_rst_n),
        .id          (id),
        .rxd         (rxd),
        .rx_dv       (rx_dv),
        .datain      (datain),
        .recv_en     (recv_en),
        .packet_en   (packet_en),
        .aux_data_in (aux_data_in),
        .aux_wr_en   (aux_wr_en)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0]  frame_q[$];
    logic [7:0]  pay_q[$];
    // Events: bit 29 = audio, low bits = written word.
    logic [29:0] exp_q[$];
    logic [29:0] got_q[$];
    bit          exp_pkt;
    bit          saw_pkt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk125) begin
        if (recv_en || aux_wr_en) check("strobe_excl", 32'(recv_en & aux_wr_en), 32'd0);
        if (recv_en)   got_q.push_back({1'b0, datain});
        if (aux_wr_en) got_q.push_back({1'b1, 5'b0, aux_data_in});
        if (packet_en) saw_pkt = 1'b1;
    end

    // Frame-level reference: walk the byte list, apply the accept rules and
    // list every complete 3-byte group inside the usable payload.
    function automatic void run_model();
        int n, i, s, hdr_n, plen, avail;
        logic [15:0] ulen;
        logic [7:0]  typ, lb;
        n = frame_q.size();
        i = 0;
        exp_q.delete();
        exp_pkt = 1'b0;
        if (n == 0 || frame_q[0] != 8'h55) return;
        while (i < n && frame_q[i] == 8'h55) i++;
        if (i >= n || frame_q[i] != 8'hD5) return;
        s = i + 1;
        hdr_n = n - s;
        if (hdr_n < 43) return;
        if ({frame_q[s+12], frame_q[s+13]} != 16'h0800) return;
        if (frame_q[s+23] != 8'h11) return;
        if ({frame_q[s+36], frame_q[s+37]} != 16'h3000 + {15'b0, id}) return;
        ulen = {frame_q[s+38], frame_q[s+39]};
        plen = int'(ulen) - 8;
        if (plen < 1) return;
        avail = plen;
        if (hdr_n - 42 < avail) avail = hdr_n - 42;
        if (2047 - 42 < avail)  avail = 2047 - 42;
        typ = frame_q[s+42];
        if (typ == 8'h00) begin
            exp_pkt = 1'b1;
            lb = frame_q[s+44];
            for (int g = 0; 5 + 3*g < avail; g++)
                exp_q.push_back({1'b0, lb[4:0], frame_q[s+45+3*g], frame_q[s+46+3*g], frame_q[s+47+3*g]});
        end else if (typ == 8'h01) begin
            exp_pkt = 1'b1;
            for (int g = 0; 3 + 3*g < avail; g++)
                exp_q.push_back({1'b1, 5'b0, frame_q[s+43+3*g], frame_q[s+44+3*g], frame_q[s+45+3*g]});
        end
    endfunction

    task automatic build_frame(input logic [15:0] etype, input logic [7:0] proto,
                               input logic [15:0] dport, input logic [15:0] ulen,
                               input logic [7:0] typ, input int n_pad);
        logic [7:0] b;
        frame_q.delete();
        repeat (7) frame_q.push_back(8'h55);
        frame_q.push_back(8'hD5);
        for (int k = 0; k < 42; k++) begin
            b = 8'($urandom);
            case (k)
                12: b = etype[15:8];
                13: b = etype[7:0];
                23: b = proto;
                36: b = dport[15:8];
                37: b = dport[7:0];
                38: b = ulen[15:8];
                39: b = ulen[7:0];
                default: ;
            endcase
            frame_q.push_back(b);
        end
        frame_q.push_back(typ);
        foreach (pay_q[k]) frame_q.push_back(pay_q[k]);
        repeat (n_pad + 4) frame_q.push_back(8'($urandom));
    endtask

    task automatic drive_byte(input logic [7:0] b);
        @(posedge clk125);
        #1;
        rx_dv = 1'b1;
        rxd   = b;
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check($sformatf("%s_word%0d", tag, k), 32'(got_q[k]), 32'(exp_q[k]));
        check({tag, "_pkt_en"}, 32'(saw_pkt), 32'(exp_pkt));
    endtask

    // cut >= 0 truncates the frame to that many bytes before sending.
    task automatic send_frame(input string tag, input int cut, input bit b2b);
        if (cut >= 0) while (frame_q.size() > cut) void'(frame_q.pop_back());
        run_model();
        got_q.delete();
        saw_pkt = 1'b0;
        foreach (frame_q[k]) drive_byte(frame_q[k]);
        @(posedge clk125);
        #1;
        rx_dv = 1'b0;
        rxd   = 8'h00;
        @(negedge clk125);
        #1;
        compare(tag);
        if (!b2b) begin
            @(negedge clk125);
            check({tag, "_pkt_idle"}, 32'(packet_en), 32'd0);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_recv_en"},   32'(recv_en),     32'd0);
        check({tag, "_aux_wr_en"}, 32'(aux_wr_en),   32'd0);
        check({tag, "_packet_en"}, 32'(packet_en),   32'd0);
        check({tag, "_datain"},    32'(datain),      32'd0);
        check({tag, "_aux_data"},  32'(aux_data_in), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind, cut, np;
        bit          b2b, video;
        logic [15:0] etype, dport, ulen;
        logic [7:0]  proto, typ;

        // Reset dominates even with preamble bytes on the wire.
        sys_rst_n = 1'b0;
        rx_dv     = 1'b1;
        rxd       = 8'h55;
        repeat (3) @(posedge clk125);
        @(negedge clk125);
        check_outputs_zero("reset");
        @(posedge clk125);
        #1;
        sys_rst_n = 1'b1;
        rx_dv     = 1'b0;
        rxd       = 8'h00;
        repeat (2) @(posedge clk125);

        // Video, id=0, line 0x025, two pixels.
        id = 1'b0;
        pay_q = '{8'h00, 8'h25, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        build_frame(16'h0800, 8'h11, 16'h3000, 16'(9 + pay_q.size()), 8'h00, 3);
        send_frame("video_basic", -1, 1'b0);

        // Audio, id=1, two words; recv_en must stay low.
        id = 1'b1;
        pay_q = '{8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34, 8'h56};
        build_frame(16'h0800, 8'h11, 16'h3001, 16'(9 + pay_q.size()), 8'h01, 2);
        send_frame("audio_basic", -1, 1'b0);

        // id=1 but frame addressed to 0x3000.
        build_frame(16'h0800, 8'h11, 16'h3000, 16'(9 + pay_q.size()), 8'h01, 2);
        send_frame("wrong_port", -1, 1'b0);

        // Video with 7 pixel bytes, rx_dv dropped inside the third pixel.
        id = 1'b0;
        pay_q = '{8'h00, 8'h13, 8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3, 8'hC1, 8'hC2, 8'hC3};
        build_frame(16'h0800, 8'h11, 16'h3000, 16'(9 + pay_q.size()), 8'h00, 0);
        send_frame("trunc_pixel", 8 + 43 + 2 + 7, 1'b0);

        // IPv6 ethertype and an unknown type byte.
        pay_q = '{8'h00, 8'h01, 8'h10, 8'h20, 8'h30};
        build_frame(16'h86DD, 8'h11, 16'h3000, 16'(9 + pay_q.size()), 8'h00, 1);
        send_frame("bad_etype", -1, 1'b0);
        build_frame(16'h0800, 8'h11, 16'h3000, 16'(9 + pay_q.size()), 8'h07, 1);
        send_frame("bad_type", -1, 1'b0);

        // Reset held two cycles inside an audio payload.
        id = 1'b1;
        pay_q.delete();
        repeat (12) pay_q.push_back(8'($urandom));
        build_frame(16'h0800, 8'h11, 16'h3001, 16'(9 + pay_q.size()), 8'h01, 0);
        while (frame_q.size() > 8 + 43 + 7) void'(frame_q.pop_back());
        run_model();
        got_q.delete();
        saw_pkt = 1'b0;
        foreach (frame_q[k]) drive_byte(frame_q[k]);
        @(posedge clk125);
        #1;
        sys_rst_n = 1'b0;
        rxd       = 8'h5A;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk125);
            #1;
            if (c == 1) begin
                sys_rst_n = 1'b1;
                rx_dv     = 1'b0;
                rxd       = 8'h00;
            end
            @(negedge clk125);
            check_outputs_zero($sformatf("midrst%0d", c));
        end
        #1;
        compare("pre_reset");
        pay_q = '{8'h01, 8'h02, 8'h03, 8'hFE, 8'hDC, 8'hBA, 8'h77};
        build_frame(16'h0800, 8'h11, 16'h3001, 16'(9 + pay_q.size()), 8'h01, 2);
        send_frame("post_reset", -1, 1'b0);

        // Oversized video frame: the byte counter saturates and strobes stop.
        id = 1'b0;
        pay_q.delete();
        pay_q.push_back(8'h00);
        pay_q.push_back(8'h09);
        repeat (2100) pay_q.push_back(8'($urandom));
        build_frame(16'h0800, 8'h11, 16'h3000, 16'(9 + pay_q.size()), 8'h00, 0);
        send_frame("saturate", -1, 1'b0);

        // Randomised frames, some truncated, some back-to-back.
        for (int f = 0; f < 30; f++) begin
            kind  = $urandom_range(0, 7);
            video = (kind % 2 == 0);
            id    = 1'($urandom_range(0, 1));
            etype = 16'h0800;
            proto = 8'h11;
            dport = 16'h3000 + {15'b0, id};
            typ   = video ? 8'h00 : 8'h01;
            pay_q.delete();
            if (video) begin
                pay_q.push_back({5'b0, 3'($urandom)});
                pay_q.push_back(8'($urandom));
            end
            np = $urandom_range(0, 20);
            repeat (np) pay_q.push_back(8'($urandom));
            ulen = 16'(9 + pay_q.size());
            case (kind)
                4: dport = 16'h3000 + {15'b0, ~id};
                5: proto = 8'h06;
                6: typ   = 8'($urandom_range(2, 255));
                7: ulen  = 16'(9 + $urandom_range(0, pay_q.size()));
                default: ;
            endcase
            build_frame(etype, proto, dport, ulen, typ, $urandom_range(0, 6));
            cut = ($urandom_range(0, 3) == 0) ? $urandom_range(8, frame_q.size() - 1) : -1;
            b2b = 1'($urandom_range(0, 1));
            send_frame($sformatf("rnd%0d_k%0d", f, kind), cut, b2b);
        end

        repeat (3) @(posedge clk125);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
